// File: rtl/cntr_bs_dp_gen.sv
// cntr_bs_dp_gen
// Parametrised bank-scheduler datapath. Holds RD_FIFO_NUM read FIFOs and
// WR_FIFO_NUM write FIFOs as circular buffers with per-FIFO occupancy
// counters. One-hot push requests are steered into the selected FIFO, and
// one-hot pops return the head entry through a registered exit stage.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   push, pop       one-hot FIFO selects (all-zero = idle)
//   dq_i .. ca_i    entry fields to store on push (dq only kept by write FIFOs)
//   grant           combinational: the push this cycle is accepted
//   full/empty/mid  per-FIFO status decoded from the registered count
//   count, last_ra  per-FIFO occupancy and RA of the last accepted push
//   valid_o .. ca_o registered exit stage (dq_o is 0 for read FIFOs)
//   err_ovf/udf/sel sticky error flags, cleared only by rst
module cntr_bs_dp_gen #(
    parameter int RD_FIFO_NUM   = 4,
    parameter int WR_FIFO_NUM   = 3,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int WR_FIFO_DEPTH = 3,
    parameter int RD_MID_LVL    = 2,
    parameter int WR_MID_LVL    = 2,
    parameter int DQ            = 16,
    parameter int IDX           = 7,
    parameter int RA            = 16,
    parameter int CA            = 10,
    localparam int FN = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int FB = (FN > 1) ? $clog2(FN) : 1,
    localparam int CB = $clog2(((RD_FIFO_DEPTH > WR_FIFO_DEPTH) ? RD_FIFO_DEPTH : WR_FIFO_DEPTH) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FN-1:0]     push,
    input  logic [FN-1:0]     pop,
    input  logic [DQ-1:0]     dq_i,
    input  logic [IDX-1:0]    idx_i,
    input  logic [RA-1:0]     ra_i,
    input  logic [CA-1:0]     ca_i,
    output logic              grant,
    output logic [FN-1:0]     full,
    output logic [FN-1:0]     empty,
    output logic [FN-1:0]     mid,
    output logic [FN*CB-1:0]  count,
    output logic [FN*RA-1:0]  last_ra,
    output logic              valid_o,
    output logic [FB-1:0]     src_o,
    output logic [DQ-1:0]     dq_o,
    output logic [IDX-1:0]    idx_o,
    output logic [RA-1:0]     ra_o,
    output logic [CA-1:0]     ca_o,
    output logic [FN-1:0]     err_ovf,
    output logic [FN-1:0]     err_udf,
    output logic              err_sel
);

    // Entry layout {dq, idx, ra, ca}: dq sits on top so read FIFOs can
    // store only the lower part and zero-extend it back on the way out.
    localparam int EW = DQ + IDX + RA + CA;

    logic          push_multi, pop_multi;
    logic          push_one, pop_one;
    logic [FN-1:0] push_sel, pop_sel;
    logic [FN-1:0] push_ok, pop_ok;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head_ent [FN];
    logic [EW-1:0] head_sel;
    logic [FB-1:0] src_sel;

    // x & (x-1) is non-zero exactly when more than one bit is set; such a
    // vector is dropped entirely while the other vector is still honoured.
    assign push_multi = |(push & (push - FN'(1)));
    assign pop_multi  = |(pop & (pop - FN'(1)));
    assign push_one   = (push != '0) && !push_multi;
    assign pop_one    = (pop != '0) && !pop_multi;
    assign push_sel   = push_one ? push : '0;
    assign pop_sel    = pop_one ? pop : '0;
    assign entry_in   = {dq_i, idx_i, ra_i, ca_i};
    assign grant      = |push_ok;

    for (genvar g = 0; g < FN; g++) begin : g_fifo
        localparam bit IS_WR = (g >= RD_FIFO_NUM);
        localparam int DEPTH = IS_WR ? WR_FIFO_DEPTH : RD_FIFO_DEPTH;
        localparam int MID   = IS_WR ? WR_MID_LVL : RD_MID_LVL;
        localparam int PW    = $clog2(DEPTH);
        localparam int SW    = IS_WR ? EW : EW - DQ;

        logic [SW-1:0] mem [DEPTH];
        logic [PW-1:0] wptr, rptr;
        logic [CB-1:0] cnt;
        logic [RA-1:0] ra_q;

        // A full FIFO still accepts a push when it is popped in the same
        // cycle; an empty FIFO never forwards a same-cycle push (no bypass).
        assign pop_ok[g]  = pop_sel[g] && (cnt != '0);
        assign push_ok[g] = push_sel[g] && ((cnt != CB'(DEPTH)) || pop_ok[g]);

        assign head_ent[g]            = EW'(mem[rptr]);
        assign full[g]                = (cnt == CB'(DEPTH));
        assign empty[g]               = (cnt == '0);
        assign mid[g]                 = (cnt >= CB'(MID));
        assign count[g*CB +: CB]      = cnt;
        assign last_ra[g*RA +: RA]    = ra_q;

        // Storage carries no reset; the cleared pointers make old contents
        // unreachable.
        always_ff @(posedge clk) begin
            if (!rst && push_ok[g]) begin
                mem[wptr] <= entry_in[SW-1:0];
            end
        end

        // Pointer, occupancy and last-RA bookkeeping for this FIFO.
        always_ff @(posedge clk) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                ra_q <= '0;
            end else begin
                if (push_ok[g]) begin
                    wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
                    ra_q <= ra_i;
                end
                if (pop_ok[g]) begin
                    rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
                end
                case ({push_ok[g], pop_ok[g]})
                    2'b10:   cnt <= cnt + CB'(1);
                    2'b01:   cnt <= cnt - CB'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Head-of-line mux for the FIFO named by the one-hot pop.
    always_comb begin
        head_sel = '0;
        src_sel  = '0;
        for (int i = 0; i < FN; i++) begin
            if (pop_sel[i]) begin
                head_sel = head_ent[i];
                src_sel  = FB'(i);
            end
        end
    end

    // Exit stage: data registers only load on a successful pop and hold
    // otherwise; valid_o drops whenever nothing was popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            src_o   <= '0;
            dq_o    <= '0;
            idx_o   <= '0;
            ra_o    <= '0;
            ca_o    <= '0;
        end else begin
            valid_o <= |pop_ok;
            if (|pop_ok) begin
                src_o                      <= src_sel;
                {dq_o, idx_o, ra_o, ca_o}  <= head_sel;
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= '0;
            err_udf <= '0;
            err_sel <= 1'b0;
        end else begin
            err_ovf <= err_ovf | (push_sel & ~push_ok);
            err_udf <= err_udf | (pop_sel & ~pop_ok);
            err_sel <= err_sel | push_multi | pop_multi;
        end
    end

endmodule
